// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit ALU issue sequencer: widths, opcodes,
// FSM state encoding and instruction field layout.
package cpu8_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned RADDR_W  = 2;
    localparam int unsigned PC_W     = 4;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned INSTR_W  = 8;

    // Instruction field positions: [7:5] op, [4:3] dst, [2:1] src, [0] last
    localparam int unsigned OP_MSB   = 7;
    localparam int unsigned OP_LSB   = 5;
    localparam int unsigned DST_MSB  = 4;
    localparam int unsigned DST_LSB  = 3;
    localparam int unsigned SRC_MSB  = 2;
    localparam int unsigned SRC_LSB  = 1;
    localparam int unsigned LAST_BIT = 0;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_MUL = 3'b101;
    localparam logic [OP_W-1:0] OP_DIV = 3'b110;
    localparam logic [OP_W-1:0] OP_EQ  = 3'b111;

    localparam logic [PC_W-1:0] PC_LAST = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [RADDR_W-1:0] dst;
        logic [RADDR_W-1:0] src;
        logic               last;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
        instr_t d;
        d.op   = raw[OP_MSB:OP_LSB];
        d.dst  = raw[DST_MSB:DST_LSB];
        d.src  = raw[SRC_MSB:SRC_LSB];
        d.last = raw[LAST_BIT];
        return d;
    endfunction

endpackage

// File: rtl/regfile_4x8.sv
// Four 8-bit registers: one synchronous write port, two combinational
// operand read ports and a combinational debug read port.
module regfile_4x8
    import cpu8_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               we_i,
    input  logic [RADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    input  logic [RADDR_W-1:0] ra_addr_i,
    output logic [DATA_W-1:0]  ra_data_o,
    input  logic [RADDR_W-1:0] rb_addr_i,
    output logic [DATA_W-1:0]  rb_data_o,
    input  logic [RADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0]  dbg_data_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Reset has priority so a write coinciding with reset is dropped
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[RADDR_W'(i)] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign ra_data_o  = regs_q[ra_addr_i];
    assign rb_data_o  = regs_q[rb_addr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_sequencer.sv
// Fetches 8-bit instructions, issues them to an external ALU and writes results back.
// Optional ALU_ISSUE_DIV0_ABORT_EN: abort program on divide-by-zero and raise error.
module alu_issue_sequencer
    import cpu8_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       load_en,
    input  logic [1:0] load_addr,
    input  logic [7:0] load_data,
    output logic       instr_req,
    output logic [3:0] instr_addr,
    input  logic       instr_valid,
    input  logic [7:0] instr_data,
    output logic [2:0] opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    output logic       busy,
    output logic       done,
    output logic       carry_flag,
    output logic       error,
    input  logic [1:0] rd_addr,
    output logic [7:0] rd_data
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    instr_t              ir_q, ir_d;
    logic                carry_q, carry_d;
    logic                rf_we;
    logic [RADDR_W-1:0]  rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic [DATA_W-1:0]   ra_data, rb_data;
    logic                div0;
    logic                in_exec;

    regfile_4x8 u_regfile (
        .clk_i      (clk),
        .reset_i    (reset),
        .we_i       (rf_we),
        .waddr_i    (rf_waddr),
        .wdata_i    (rf_wdata),
        .ra_addr_i  (ir_q.dst),
        .ra_data_o  (ra_data),
        .rb_addr_i  (ir_q.src),
        .rb_data_o  (rb_data),
        .dbg_addr_i (rd_addr),
        .dbg_data_o (rd_data)
    );

`ifdef ALU_ISSUE_DIV0_ABORT_EN
    logic error_q, error_d;
    assign div0 = (ir_q.op == OP_DIV) && (rb_data == '0);
`else
    assign div0 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            carry_q <= 1'b0;
`ifdef ALU_ISSUE_DIV0_ABORT_EN
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
`ifdef ALU_ISSUE_DIV0_ABORT_EN
            error_q <= error_d;
`endif
        end
    end

    // Next-state, PC/IR update and register-file write control
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        carry_d  = carry_q;
        rf_we    = 1'b0;
        rf_waddr = ir_q.dst;
        rf_wdata = alu_result;
`ifdef ALU_ISSUE_DIV0_ABORT_EN
        error_d  = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
`ifdef ALU_ISSUE_DIV0_ABORT_EN
                    error_d = 1'b0;
`endif
                end else if (load_en) begin
                    rf_we    = 1'b1;
                    rf_waddr = load_addr;
                    rf_wdata = load_data;
                end
            end
            ST_FETCH: begin
                if (instr_valid) begin
                    ir_d    = decode_instr(instr_data);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (div0) begin
                    carry_d = 1'b1;
                    state_d = ST_DONE;
`ifdef ALU_ISSUE_DIV0_ABORT_EN
                    error_d = 1'b1;
`endif
                end else begin
                    rf_we   = 1'b1;
                    carry_d = alu_carry;
                    // PC saturates at the last address: a program never wraps
                    if (ir_q.last || (pc_q == PC_LAST)) begin
                        state_d = ST_DONE;
                    end else begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_exec    = (state_q == ST_EXEC);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign instr_req  = (state_q == ST_FETCH);
    assign instr_addr = instr_req ? pc_q : '0;
    assign opcode     = in_exec ? ir_q.op : '0;
    assign alu_a      = in_exec ? ra_data : '0;
    assign alu_b      = in_exec ? rb_data : '0;
    assign carry_flag = carry_q;

`ifdef ALU_ISSUE_DIV0_ABORT_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Scoreboard bench for alu_issue_sequencer: the bench plays instruction memory
// and ALU, predicts issue/writeback per instruction and checks them as they appear.
module tb_alu_issue_sequencer;
    import cpu8_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       load_en = 1'b0;
    logic [1:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       instr_req;
    logic [3:0] instr_addr;
    logic       instr_valid = 1'b0;
    logic [7:0] instr_data = '0;
    logic [2:0] opcode;
    logic [7:0] alu_a, alu_b;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       busy, done, carry_flag, error;
    logic [1:0] rd_addr = '0;
    logic [7:0] rd_data;

    always #5 clk = ~clk;

    alu_issue_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .opcode      (opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry),
        .busy        (busy),
        .done        (done),
        .carry_flag  (carry_flag),
        .error       (error),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    // Reference ALU: returns {carry, result}
    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        case (op)
            OP_ADD: alu_f = {1'b0, a} + {1'b0, b};
            OP_SUB: alu_f = {1'b0, a} - {1'b0, b};
            OP_AND: alu_f = {1'b0, a & b};
            OP_OR:  alu_f = {1'b0, a | b};
            OP_XOR: alu_f = {1'b0, a ^ b};
            OP_MUL: begin
                p = 16'(a) * 16'(b);
                alu_f = {|p[15:8], p[7:0]};
            end
            OP_DIV: alu_f = (b == 8'h00) ? {1'b1, 8'h00} : {1'b0, a / b};
            default: alu_f = {1'b0, 7'h00, (a == b)};
        endcase
    endfunction

    always_comb {alu_carry, alu_result} = alu_f(opcode, alu_a, alu_b);

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] dst;
        logic [7:0] wb;
        logic       carry;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] mdl_regs [4];
    logic       mdl_carry;
    logic       mdl_err;
    logic [7:0] prog_mem [16];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mdl_regs[i] = 8'h00;
        mdl_carry = 1'b0;
        mdl_err   = 1'b0;
        sb_q.delete();
    endtask

    task automatic preload(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        mdl_regs[a] = d;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            check_val($sformatf("%s_r%0d", tag, i), 32'(rd_data), 32'(mdl_regs[i]));
        end
        check_val({tag, "_carry"}, 32'(carry_flag), 32'(mdl_carry));
        check_val({tag, "_error"}, 32'(error), 32'(mdl_err));
    endtask

    // Start a program in prog_mem; optional FETCH stall on the first instruction
    task automatic run_prog(input int stall, input bit load_at_start);
        int         pc;
        int         t;
        bit         fin;
        bit         abort;
        exp_t       e;
        exp_t       got;
        logic [8:0] cr;
        @(negedge clk);
        start = 1'b1;
        if (load_at_start) begin
            load_en = 1'b1; load_addr = 2'd2; load_data = 8'h55;
        end
        @(negedge clk);
        start = 1'b0; load_en = 1'b0;
        mdl_err = 1'b0;
        pc = 0; fin = 1'b0;
        while (!fin) begin
            t = 0;
            while (instr_req !== 1'b1 && t < 8) begin
                @(negedge clk);
                t++;
            end
            check_val("fetch_req", 32'(instr_req), 32'd1);
            check_val("fetch_addr", 32'(instr_addr), 32'(pc));
            if (pc == 0 && stall > 0) begin
                start = 1'b1; load_en = 1'b1; load_addr = 2'd0; load_data = 8'hAA;
                rd_addr = 2'd0;
                for (int k = 0; k < stall; k++) begin
                    @(negedge clk);
                    check_val("stall_req", 32'(instr_req), 32'd1);
                    check_val("stall_addr", 32'(instr_addr), 32'(pc));
                    check_val("stall_issue", {21'(0), opcode, alu_a ^ alu_b, 8'(alu_a | alu_b)}, 32'd0);
                    check_val("stall_busy", 32'(busy), 32'd1);
                    check_val("stall_r0", 32'(rd_data), 32'(mdl_regs[0]));
                end
                start = 1'b0; load_en = 1'b0;
            end
            instr_valid = 1'b1;
            instr_data  = prog_mem[pc];
            e.op  = instr_data[7:5];
            e.dst = instr_data[4:3];
            e.a   = mdl_regs[instr_data[4:3]];
            e.b   = mdl_regs[instr_data[2:1]];
            cr    = alu_f(e.op, e.a, e.b);
            abort = 1'b0;
`ifdef ALU_ISSUE_DIV0_ABORT_EN
            abort = (e.op == OP_DIV) && (e.b == 8'h00);
`endif
            if (abort) begin
                e.wb = e.a; e.carry = 1'b1; mdl_err = 1'b1;
            end else begin
                e.wb = cr[7:0]; e.carry = cr[8];
                mdl_regs[e.dst] = cr[7:0];
            end
            mdl_carry = e.carry;
            sb_q.push_back(e);
            fin = instr_data[0] || (pc == 15) || abort;
            @(negedge clk);
            instr_valid = 1'b0;
            got = sb_q.pop_front();
            check_val("exec_opcode", 32'(opcode), 32'(got.op));
            check_val("exec_alu_a", 32'(alu_a), 32'(got.a));
            check_val("exec_alu_b", 32'(alu_b), 32'(got.b));
            check_val("exec_req", 32'(instr_req), 32'd0);
            rd_addr = got.dst;
            @(negedge clk);
            check_val("wb_data", 32'(rd_data), 32'(got.wb));
            check_val("wb_carry", 32'(carry_flag), 32'(got.carry));
            if (!fin) pc++;
        end
        check_val("done_pulse", 32'(done), 32'd1);
        check_val("done_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_val("idle_done", 32'(done), 32'd0);
        check_val("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_req", 32'(instr_req), 32'd0);
        check_val("rst_issue", {13'(0), instr_addr, opcode, alu_a, alu_b}, 32'd0);
        check_regs("rst");

        // ADD without carry
        preload(2'd0, 8'h05); preload(2'd1, 8'h03);
        prog_mem[0] = 8'h03;
        run_prog(0, 1'b0);
        check_regs("add");

        // ADD with carry out
        preload(2'd0, 8'hF0); preload(2'd1, 8'h20);
        run_prog(0, 1'b0);
        check_regs("add_carry");

        // Divide by zero
        preload(2'd2, 8'h09); preload(2'd3, 8'h00);
        prog_mem[0] = 8'hD7;
        run_prog(0, 1'b0);
        check_regs("div0");

        // Mixed ops, 5-cycle fetch stall with start/load_en asserted while busy
        preload(2'd3, 8'h07);
        prog_mem[0] = 8'h2C; prog_mem[1] = 8'h90; prog_mem[2] = 8'hBA; prog_mem[3] = 8'hE1;
        run_prog(5, 1'b0);
        check_regs("mixed");

        // Full 16-instruction program; load_en alongside start is ignored
        preload(2'd0, 8'h00); preload(2'd1, 8'h01);
        for (int i = 0; i < 16; i++) prog_mem[i] = 8'h02;
        run_prog(0, 1'b1);
        check_regs("prog16");

        // Reset landing on an EXEC cycle
        preload(2'd0, 8'h05); preload(2'd1, 8'h03);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        instr_valid = 1'b1; instr_data = 8'h03;
        @(negedge clk); instr_valid = 1'b0;
        check_val("pre_rst_alu_a", 32'(alu_a), 32'h05);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_clear();
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_done", 32'(done), 32'd0);
        check_val("mid_rst_issue", {12'(0), instr_req, instr_addr, opcode, alu_a, alu_b}, 32'd0);
        check_regs("mid_rst");
        @(negedge clk);
        check_val("mid_rst_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
